regs_wr_arbiter: RTL
====================

# regs_wr_arbiter

Write-port controller for the `Regs` register file: shares its single write port (`wen`/`addrw`/`dinw`) among `NR_REQ` requesters with round-robin arbitration and a valid/ready handshake. It also hosts a clear sequencer that sweeps registers 1..`NR_REGS-1` to zero on command. It sits between the writeback sources (ALU, load unit, CSR path) and the register file. Its outputs are registered and connect directly to the `Regs` write ports.

## Interface
- `WIDTH`, 32, register data width
- `NR_REGS`, 32, number of registers; register 0 is hard-wired zero
- `ADDR_WIDTH`, 5, register address width
- `NR_REQ`, 2, number of write requesters (2..8)

- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  `NR_REQ`  per-requester write request
- `req_addr`  in  `NR_REQ*ADDR_WIDTH`  packed destination addresses; requester i occupies slice [(i+1)*ADDR_WIDTH-1 -: ADDR_WIDTH]
- `req_data`  in  `NR_REQ*WIDTH`  packed write data; requester i occupies slice [(i+1)*WIDTH-1 -: WIDTH]
- `req_ready`  out  `NR_REQ`  one-hot grant; a handshake is `req_valid[i] && req_ready[i]`
- `clr_start`  in  1  pulse requesting a register-file clear
- `busy`  out  1  high while the clear sequence runs
- `wen`  out  1  register-file write enable (registered)
- `addrw`  out  `ADDR_WIDTH`  register-file write address (registered)
- `dinw`  out  `WIDTH`  register-file write data (registered)

## Operation
- There are two states: ARB and CLEAR. Reset enters ARB.
- **ARB state**
  - `req_ready` is combinational from `req_valid`, the round-robin pointer `last`, and the state.
  - Search order starts at requester `last+1` and wraps modulo `NR_REQ`. The first valid requester in that order is granted.
  - At most one `req_ready` bit is high. `req_ready` is all-zero when no request is valid.
  - On a handshake, `last` takes the granted index.
  - On a handshake, `wen/addrw/dinw` register the granted request.
  - If the granted address is 0 or is ≥ `NR_REGS`, the handshake still completes but `wen` registers 0. `addrw`/`dinw` are still loaded.
  - With no handshake, `wen` registers 0 and `addrw`/`dinw` hold their values.
- **Requester rules**
  - A requester holds `req_valid`, `req_addr` and `req_data` stable until it sees ready.
  - The arbiter does not depend on this: it samples only at the handshake edge.
- **Entering CLEAR**
  - `clr_start` high in ARB moves the state to CLEAR at the next edge.
  - `clr_start` has priority over requests: in that cycle `req_ready` is all-zero, so no handshake occurs.
  - The clear counter `cnt` loads 1 on entry.
- **CLEAR state**
  - `req_ready` is all-zero and `busy` is 1.
  - Each cycle: `wen` registers 1, `addrw` registers `cnt`, `dinw` registers 0, and `cnt` increments.
  - When `cnt == NR_REGS-1` is issued, the state returns to ARB.
  - `clr_start` is ignored while in CLEAR.
  - `last` is unchanged by a clear.
- **Reset**, at any time including mid-clear:
  - state ARB, `last = NR_REQ-1` (requester 0 has first priority), `cnt = 1`
  - `wen = 0`, `addrw = 0`, `dinw = 0`, `busy = 0`
  - The partial clear is abandoned.

## Timing
- **Handshake to write enable**: a handshake at edge N produces `wen/addrw/dinw` valid during cycle N..N+1. `Regs` commits the write at edge N+1, so the write is visible on the `Regs` read port after edge N+1.
- **Back-to-back grants**: full throughput, one write per cycle. Alternating valid requesters are granted in alternating cycles.
- **Clear duration**:
  - `clr_start` sampled at edge N: `busy` is 1 from after edge N to after edge N+`NR_REGS-1`.
  - Writes appear on cycles N+1..N+`NR_REGS-1`.
  - `req_ready` may assert again in the cycle after `busy` falls.
- **busy**: registered, equal to (state == CLEAR).
- **Reset values**: all outputs are 0 after reset. `req_ready` is combinational and follows the rules above in the first cycle after reset.

## Test plan
- **Reset priority**: after reset, `req_valid=2'b11` with req0 addr 3 data 0xAAAA_0001 and req1 addr 4 data 0xBBBB_0002.
  - Cycle 1 grants req0.
  - Cycle 2 grants req1.
  - `wen=1` with `addrw` 3 then 4 on the following cycles.
  - `Regs` reads back 0xAAAA_0001 and 0xBBBB_0002.
- **Fairness**: hold `req_valid=2'b11` for 6 cycles -> grants alternate 0,1,0,1,0,1 and exactly one `req_ready` bit is high each cycle.
- **Zero register**: req0 writes addr 0 data 0xDEAD_BEEF -> `req_ready[0]=1`, next-cycle `wen=0`, and `Regs` read of addr 0 returns 0.
- **Clear**:
  - Preload regs 1..31 with nonzero values, then pulse `clr_start` together with `req_valid[1]=1`.
  - No grant in that cycle.
  - `busy=1` for 31 cycles.
  - `addrw` sweeps 1..31 with `dinw=0` and `wen=1`.
  - All regs read 0 afterwards.
  - req1 is granted on the cycle after `busy` falls.
- **Reset mid-clear**: assert `rst` during the clear at `cnt=10` -> next cycle `busy=0` and `wen=0`; regs 10..31 keep their preloaded values.
- **Stall hold**: with a clear running, `req_valid[0]=1` held with stable addr 7 data 0x1234 -> no ready during `busy`; granted once ARB resumes; reg 7 = 0x1234.

Source files
------------

// File: rtl/regs_wr_arbiter_if.sv
// Write-request bus between the writeback sources and the Regs write-port arbiter,
// plus the registered write port and clear-control signals it drives.
interface regs_wr_arbiter_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NR_REQ     = 2
);
  logic [NR_REQ-1:0]            req_valid;
  logic [NR_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NR_REQ*WIDTH-1:0]      req_data;
  logic [NR_REQ-1:0]            req_ready;
  logic                         clr_start;
  logic                         busy;
  logic                         wen;
  logic [ADDR_WIDTH-1:0]        addrw;
  logic [WIDTH-1:0]             dinw;

  modport master (
    output req_valid, req_addr, req_data, clr_start,
    input  req_ready, busy, wen, addrw, dinw
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_start,
    output req_ready, busy, wen, addrw, dinw
  );
endinterface

// File: rtl/regs_wr_arbiter.sv
// Round-robin owner of the Regs write port with a register-clear sweep; writes are registered one cycle after handshake.
// Backpressure: req_ready is a one-hot grant, forced low while clearing or when clr_start is seen.
module regs_wr_arbiter #(
  parameter int WIDTH      = 32,
  parameter int NR_REGS    = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NR_REQ     = 2
) (
  input  logic             clk,
  input  logic             rst,
  regs_wr_arbiter_if.slave bus
);

  localparam int                    IDX_W     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam logic [IDX_W:0]        NR_REQ_W  = (IDX_W+1)'(NR_REQ);
  localparam logic [ADDR_WIDTH:0]   NR_REGS_W = (ADDR_WIDTH+1)'(NR_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NR_REGS - 1);

  generate
    if (NR_REQ < 2 || NR_REQ > 8) begin : g_bad_nr_req
      $error("regs_wr_arbiter: NR_REQ must be in 2..8");
    end
    if (NR_REGS < 2 || NR_REGS > (1 << ADDR_WIDTH)) begin : g_bad_nr_regs
      $error("regs_wr_arbiter: NR_REGS must fit in ADDR_WIDTH");
    end
  endgenerate

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IDX_W-1:0]      last;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W:0]        sum;
  logic [NR_REQ-1:0]     grant;
  logic                  found;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] cnt;

  logic [ADDR_WIDTH-1:0] addr_arr [NR_REQ];
  logic [WIDTH-1:0]      data_arr [NR_REQ];
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;

  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addrw_q;
  logic [WIDTH-1:0]      dinw_q;
  logic                  busy_q;

  // Register 0 is hard-wired zero and addresses past the file do not exist.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && ({1'b0, a} < NR_REGS_W);
  endfunction

  for (genvar g = 0; g < NR_REQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.req_addr[(g+1)*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign data_arr[g] = bus.req_data[(g+1)*WIDTH-1 -: WIDTH];
  end

  // Search starts one past the last winner and wraps; clr_start pre-empts all requests.
  always_comb begin
    grant     = '0;
    grant_idx = last;
    found     = 1'b0;
    idx       = '0;
    sum       = '0;
    if (state == ARB && !bus.clr_start) begin
      for (int k = 0; k < NR_REQ; k++) begin
        sum = {1'b0, last} + (IDX_W+1)'(k + 1);
        idx = (sum >= NR_REQ_W) ? IDX_W'(sum - NR_REQ_W) : IDX_W'(sum);
        if (!found && bus.req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = idx;
        end
      end
    end
  end

  assign hs       = |grant;
  assign sel_addr = addr_arr[grant_idx];
  assign sel_data = data_arr[grant_idx];

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (bus.clr_start) state_nxt = CLEAR;
      CLEAR:   if (cnt == LAST_REG) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= IDX_W'(NR_REQ - 1);
      cnt     <= ADDR_WIDTH'(1);
      wen_q   <= 1'b0;
      addrw_q <= '0;
      dinw_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_nxt == CLEAR);
      case (state)
        ARB: begin
          cnt <= ADDR_WIDTH'(1);
          if (hs) begin
            last    <= grant_idx;
            wen_q   <= addr_ok(sel_addr);
            addrw_q <= sel_addr;
            dinw_q  <= sel_data;
          end else begin
            wen_q <= 1'b0;
          end
        end
        CLEAR: begin
          wen_q   <= 1'b1;
          addrw_q <= cnt;
          dinw_q  <= '0;
          cnt     <= cnt + ADDR_WIDTH'(1);
        end
        default: wen_q <= 1'b0;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.busy      = busy_q;
  assign bus.wen       = wen_q;
  assign bus.addrw     = addrw_q;
  assign bus.dinw      = dinw_q;

endmodule
